// File: rtl/router_output_arbiter.sv
// Per-output-port arbiter with a two-entry even/odd VC output buffer for the mesh router.
// Optional feature: define ARB_HOP_UPDATE_EN to halve the hop field [55:48] on every buffer write.
module router_output_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          polarity,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          ch_so,
    output logic [DATA_WIDTH-1:0]         ch_do,
    input  logic                          ch_ro
);
    localparam int RR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int VC_BIT  = DATA_WIDTH - 1;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;

    logic                  polarity_q, polarity_d;
    logic [1:0]            full_q, full_d;
    logic [RR_W-1:0]       rr_q  [2];
    logic [RR_W-1:0]       rr_d  [2];
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];

    logic                  fill_vc, drain_vc;
    logic [NUM_REQ-1:0]    elig;
    logic                  grant_vld;
    logic [RR_W-1:0]       winner;
    logic [DATA_WIDTH-1:0] win_data, win_stored;

    // Fill and drain sides are always opposite VCs, so a buffer is never read and written together.
    assign fill_vc  = polarity_q;
    assign drain_vc = ~polarity_q;
    assign polarity = polarity_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign elig[gi] = req[gi] & (req_data[gi*DATA_WIDTH + VC_BIT] == fill_vc);
        end
    endgenerate

    // Round-robin search starting at the fill VC's pointer, wrapping past NUM_REQ-1.
    always_comb begin
        logic [RR_W:0] cand;
        grant_vld = 1'b0;
        winner    = '0;
        cand      = '0;
        if (!full_q[fill_vc]) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_q[fill_vc]} + (RR_W+1)'(k);
                if (cand >= (RR_W+1)'(NUM_REQ)) begin
                    cand = cand - (RR_W+1)'(NUM_REQ);
                end
                if (!grant_vld && elig[cand[RR_W-1:0]]) begin
                    grant_vld = 1'b1;
                    winner    = cand[RR_W-1:0];
                end
            end
        end
    end

    assign win_data = req_data[winner*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        win_stored = win_data;
`ifdef ARB_HOP_UPDATE_EN
        win_stored[HOP_MSB:HOP_LSB] = {1'b0, win_data[HOP_MSB:HOP_LSB+1]};
`endif
    end

    always_comb begin
        gnt = '0;
        if (grant_vld && reset) begin
            gnt[winner] = 1'b1;
        end
    end

    assign ch_so = reset & full_q[drain_vc] & ch_ro;
    assign ch_do = ch_so ? buf_q[drain_vc] : '0;

    always_comb begin
        polarity_d = ~polarity_q;
        full_d     = full_q;
        rr_d       = rr_q;
        buf_d      = buf_q;
        if (ch_so) begin
            full_d[drain_vc] = 1'b0;
        end
        if (grant_vld) begin
            full_d[fill_vc] = 1'b1;
            buf_d[fill_vc]  = win_stored;
            rr_d[fill_vc]   = (winner == RR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity_q <= 1'b0;
            full_q     <= 2'b00;
            for (int v = 0; v < 2; v++) begin
                rr_q[v]  <= '0;
                buf_q[v] <= '0;
            end
        end else begin
            polarity_q <= polarity_d;
            full_q     <= full_d;
            for (int v = 0; v < 2; v++) begin
                rr_q[v]  <= rr_d[v];
                buf_q[v] <= buf_d[v];
            end
        end
    end

endmodule

// File: doc/router_output_arbiter.md
# router_output_arbiter

Per-output-port arbiter and output buffer for the mesh router. It shares one outgoing link between the router's input channels (N, S, E, W, PE) and uses the even/odd virtual channel (VC) scheme. It generates the router's `polarity` phase signal, picks one packet per cycle round-robin for the VC being filled, and drains the other VC's buffer onto the link under the downstream ready handshake. One instance sits in front of each router output channel.

## Interface
- `DATA_WIDTH`, default 64: packet width. Bit 63 = VC, [62:61] = direction, [55:48] = hop field, [47:32] = source, [31:0] = payload.
- `NUM_REQ`, default 5: number of requesters. Index 4 = PE; indices 0..3 = N, S, E, W.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low. 0 = held in reset.
- `polarity`, output, 1: phase bit. Toggles every cycle.
- `req`, input, NUM_REQ: requester i holds a head packet for this port.
- `req_data`, input, NUM_REQ*DATA_WIDTH: packet of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt`, output, NUM_REQ: one-hot grant, combinational. Requester i pops its packet at the next edge.
- `ch_so`, output, 1: link send strobe.
- `ch_do`, output, DATA_WIDTH: link data.
- `ch_ro`, input, 1: downstream buffer ready.

## Operation
- State:
  - `buf[0]`, `buf[1]`: DATA_WIDTH each.
  - `full[0..1]`.
  - Round-robin pointers `rr[0..1]`: 0..NUM_REQ-1 each.
  - `polarity` register.
- Phase rule: in a cycle with `polarity`=p:
  - VC p is the fill side (internal).
  - VC ~p is the drain side (link).
  - The same buffer is never read and written in the same cycle.
- Fill:
  - `elig[i] = req[i] & (req_data[i][63] == p)`.
  - If `full[p]`==0 and `elig`!=0: `gnt` = one-hot of the first eligible index searching from `rr[p]` upward, wrapping NUM_REQ-1 -> 0.
  - At the edge: `buf[p]` <= winner data; `full[p]` <= 1; `rr[p]` <= (winner+1) mod NUM_REQ.
  - Otherwise `gnt` = 0 and `buf[p]`/`rr[p]` hold.
- Drain:
  - `ch_so = full[~p] & ch_ro`.
  - `ch_do = buf[~p]` when `ch_so`=1, else 0.
  - At the edge with `ch_so`=1, `full[~p]` <= 0.
- Requests whose VC bit does not match p are ignored that cycle. They are considered again next cycle.
- Requesters hold `req`/`req_data` stable until granted. The arbiter never drops or duplicates a packet.

## Timing
- Reset values (asserted asynchronously):
  - `polarity`=0, `full`=00, `rr[0]`=`rr[1]`=0, `buf` contents = 0.
  - Outputs: `gnt`=0, `ch_so`=0, `ch_do`=0.
- Release is synchronous to the next rising edge. First cycle after release: `polarity`=0, VC0 fill.
- Latency: a packet granted in cycle t (`polarity`=p) appears on `ch_so`/`ch_do` in cycle t+1 at the earliest, when `polarity`=~p and `ch_ro`=1.
- `ch_ro`=0 in the drain cycle: the buffer stays full and the send is retried 2 cycles later. Fill of that VC is blocked meanwhile (`gnt`=0 for that VC).
- Throughput: at most 1 packet per VC per 2 cycles. The link sustains 1 packet/cycle when both VCs are loaded and `ch_ro` is held at 1.
- Buffer full with more eligible requests: no grant, and `rr` does not advance.
- Reset asserted mid-operation: buffered packets are discarded. No `ch_so` pulse is emitted during or after reset until a new grant occurs.

## Configuration
- Macro: `ARB_HOP_UPDATE_EN`.
- Defined: on a buffer write, hop field [55:48] is stored logically right-shifted by 1 (8'b0001_0000 -> 8'b0000_1000). All other bits are unchanged.
- Undefined: packets are stored and forwarded bit-exact.

## Test plan
- Reset/phase:
  - Stimulus: hold `reset`=0 for 3 cycles, then release.
  - Required: `gnt`/`ch_so`/`ch_do`=0 throughout reset. `polarity` is 0 in the first cycle after release and then alternates 1,0,1.
- Single PE packet:
  - Stimulus: `req`=5'b10000, data {1'b0, 2'b10, 5'b0, 8'h10, 16'h0000, 32'h1111_1111}, `ch_ro`=1.
  - Required: `gnt`=5'b10000 in the first `polarity`=0 cycle. The next cycle `ch_so`=1 with `ch_do` equal to the packet (hop field = 8'h08 with `ARB_HOP_UPDATE_EN`).
- VC mismatch:
  - Stimulus: same packet with bit63=1, presented during a `polarity`=0 cycle.
  - Required: `gnt`=0 that cycle. Granted in the following `polarity`=1 cycle.
- Round-robin fairness:
  - Stimulus: all 5 requesters continuously request VC0, `ch_ro`=1.
  - Required: VC0 grants rotate through indices 0,1,2,3,4,0 on successive `polarity`=0 cycles.
- Backpressure:
  - Stimulus: VC0 buffer full and `ch_ro`=0 for 4 cycles.
  - Required: `ch_so`=0, no further VC0 grants, buffer data unchanged. After `ch_ro`=1, exactly one send occurs in the next `polarity`=1 cycle.
- Reset mid-flight:
  - Stimulus: assert `reset` while `full`=11.
  - Required: `ch_so` drops to 0 immediately. After release, no packet is emitted without a new request.
